imem_port_arbiter: RTL and testbench
====================================

// Module: imem_port_arbiter
// PURPOSE
//  Shares the single-ported, synchronous-read instruction memory between two requesters:
//  port 0 = IF-stage fetch, port 1 = MEM-stage read (e.g. PC-relative constant loads).
//  Issues at most one memory read per cycle and routes each response back to its requester.
//  Sits between pc_reg/mem stages and the instruction memory. Drives stallreq for the ctrl block.
// PARAMETERS
//  ADDR_W     32  byte-address width of both requester ports
//  DATA_W     32  word width of memory and responses
//  IDX_W      17  word-index width to memory (log2 of memory depth)
// PORTS
//  clk          in   1       clock; all state updates on rising edge
//  rst          in   1       asynchronous, active-low reset
//  req0         in   1       fetch request, held with addr0 until gnt0
//  addr0        in   ADDR_W  fetch byte address
//  gnt0         out  1       request 0 accepted this cycle (combinational)
//  rvalid0      out  1       rdata0 valid, one cycle after gnt0
//  rdata0       out  DATA_W  fetch response word
//  req1         in   1       data-side read request, held with addr1 until gnt1
//  addr1        in   ADDR_W  data-side byte address
//  gnt1         out  1       request 1 accepted this cycle (combinational)
//  rvalid1      out  1       rdata1 valid, one cycle after gnt1
//  rdata1       out  DATA_W  data-side response word
//  err1         out  1       with rvalid1: addr1[1:0]!=0 (misaligned), rdata1 forced to 0
//  stallreq_if  out  1       req0 & ~gnt0; fetch must hold PC
//  mem_ce       out  1       memory read enable
//  mem_idx      out  IDX_W   word index = granted addr[IDX_W+1:2]
//  mem_rdata    in   DATA_W  memory data, valid the cycle after mem_ce
// BEHAVIOUR
//  Reset (rst=0, async): gnt0/1=0, rvalid0/1=0, rdata0/1=0, err1=0, mem_ce=0, mem_idx=0,
//   state=IDLE, rr_last=1 (so port 0 wins first contention). Outstanding read is discarded.
//  Grant (combinational, one per cycle):
//   - only req0 -> gnt0; only req1 -> gnt1; neither -> no grant, mem_ce=0.
//   - both -> round-robin: grant the port NOT equal to rr_last.
//   - rr_last updates to the granted port on every grant.
//  Misaligned req1: still granted (consumes the cycle); mem_ce=0 for that cycle; response
//   next cycle is rvalid1=1, err1=1, rdata1=0. Misaligned addr0 is not checked (low 2 bits dropped).
//  State register (owner of the in-flight read): IDLE, RESP0, RESP1, RESP1_ERR.
//   - any state -> RESP0 on gnt0; -> RESP1 on aligned gnt1; -> RESP1_ERR on misaligned gnt1;
//     -> IDLE when no grant. A new grant may issue every cycle (fully pipelined).
//  Responses (latency exactly 1 cycle after grant):
//   - RESP0: rvalid0=1, rdata0=mem_rdata. RESP1: rvalid1=1, rdata1=mem_rdata, err1=0.
//   - rdata/err of the non-owning port read 0; rvalid high for exactly one cycle per grant.
//  stallreq_if asserts whenever fetch loses arbitration. No stall is generated for port 1;
//   the MEM stage waits on gnt1 itself.
//  Requester must not change addr while req is high and gnt low; a dropped req is legal and
//   removes the port from arbitration that cycle.
//  Reset mid-read: response of the in-flight grant is never delivered; no rvalid after release.
// TESTING
//  1 reset, then req0=1 addr0=0x0000_0008 only -> gnt0=1, mem_ce=1, mem_idx=2; next cycle
//    rvalid0=1, rdata0=mem[2]; stallreq_if=0.
//  2 req0 and req1 held high 4 cycles (addr0=0x0, addr1=0x10) -> grants 0,1,0,1;
//    rvalid0/rvalid1 alternate one cycle later; stallreq_if=0,1,0,1.
//  3 req1 addr1=0x0000_0006 -> gnt1=1, mem_ce=0; next cycle rvalid1=1, err1=1, rdata1=0.
//  4 back-to-back req0 at 0x0,0x4,0x8 -> one result per cycle in order, mem[0],mem[1],mem[2].
//  5 gnt1 issued, rst pulsed low mid-cycle before response -> all outputs 0 immediately;
//    no rvalid1 after release; first contention after reset grants port 0.
//  6 no requests for 3 cycles -> mem_ce=0, gnt0/1=0, rvalid0/1=0 throughout.

Source files
------------

// File: rtl/imem_port_arbiter.sv
// Two-port arbiter sharing a single-ported synchronous-read instruction memory (fetch / data-side read).
// Grant is combinational; response arrives exactly 1 cycle after grant, fully pipelined.
// A losing fetch raises stallreq_if; a losing data-side request simply waits for gnt1.
module imem_port_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int IDX_W  = 17
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic [ADDR_W-1:0] addr0,
   output logic              gnt0,
   output logic              rvalid0,
   output logic [DATA_W-1:0] rdata0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] addr1,
   output logic              gnt1,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata1,
   output logic              err1,
   output logic              stallreq_if,
   output logic              mem_ce,
   output logic [IDX_W-1:0]  mem_idx,
   input  logic [DATA_W-1:0] mem_rdata
);

   // Owner of the read currently in flight (the one whose data arrives this cycle).
   typedef enum logic [1:0] {IDLE, RESP0, RESP1, RESP1_ERR} state_e;

   state_e     state_q, state_d;
   logic       rr_last_q, rr_last_d;
   logic       gnt0_c, gnt1_c;
   logic       mis1;
   logic       mem_ce_c;
   logic [IDX_W-1:0] mem_idx_c;

   // Address bits that never reach the memory (byte offset of fetch, bits above the index).
   logic unused_addr_bits;
   assign unused_addr_bits = ^{addr0[ADDR_W-1:IDX_W+2], addr0[1:0], addr1[ADDR_W-1:IDX_W+2]};

   assign mis1 = (addr1[1:0] != 2'b00);

   // Arbitration: single requester wins outright; on contention the port that did not win last time.
   // Grants are held off while reset is asserted so all outputs read 0 immediately.
   always_comb begin
      gnt0_c = 1'b0;
      gnt1_c = 1'b0;
      if (rst) begin
         if (req0 && req1) begin
            if (rr_last_q) gnt0_c = 1'b1;
            else           gnt1_c = 1'b1;
         end else if (req0) begin
            gnt0_c = 1'b1;
         end else if (req1) begin
            gnt1_c = 1'b1;
         end
      end
   end

   // Next owner, round-robin pointer and memory command; a misaligned data read consumes the slot
   // without touching memory so its error response can be produced locally.
   always_comb begin
      state_d   = IDLE;
      rr_last_d = rr_last_q;
      mem_ce_c  = 1'b0;
      mem_idx_c = '0;
      if (gnt0_c) begin
         state_d   = RESP0;
         rr_last_d = 1'b0;
         mem_ce_c  = 1'b1;
         mem_idx_c = addr0[IDX_W+1:2];
      end else if (gnt1_c) begin
         rr_last_d = 1'b1;
         if (mis1) begin
            state_d = RESP1_ERR;
         end else begin
            state_d   = RESP1;
            mem_ce_c  = 1'b1;
            mem_idx_c = addr1[IDX_W+1:2];
         end
      end
   end

   // State and round-robin registers; reset drops any in-flight read and favours port 0 next.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         rr_last_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         rr_last_q <= rr_last_d;
      end
   end

   assign gnt0        = gnt0_c;
   assign gnt1        = gnt1_c;
   assign mem_ce      = mem_ce_c;
   assign mem_idx     = mem_idx_c;
   assign stallreq_if = rst & req0 & ~gnt0_c;

   assign rvalid0 = (state_q == RESP0);
   assign rdata0  = (state_q == RESP0) ? mem_rdata : '0;
   assign rvalid1 = (state_q == RESP1) || (state_q == RESP1_ERR);
   assign rdata1  = (state_q == RESP1) ? mem_rdata : '0;
   assign err1    = (state_q == RESP1_ERR);

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a small synchronous-read memory model.
// Memory word i holds 32'hA500_0000 + i.
module tb_imem_port_arbiter;

   logic        clk;
   logic        rst;
   logic        req0, req1;
   logic [31:0] addr0, addr1;
   logic        gnt0, gnt1, rvalid0, rvalid1, err1, stallreq_if, mem_ce;
   logic [31:0] rdata0, rdata1, mem_rdata;
   logic [16:0] mem_idx;

   int total = 0;
   int bad   = 0;

   imem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .IDX_W(17)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .addr0(addr0), .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
      .req1(req1), .addr1(addr1), .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
      .err1(err1), .stallreq_if(stallreq_if),
      .mem_ce(mem_ce), .mem_idx(mem_idx), .mem_rdata(mem_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial mem_rdata = 32'hDEAD_BEEF;
   always @(posedge clk) begin
      if (mem_ce) mem_rdata <= 32'hA500_0000 + 32'(mem_idx);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b0; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
      tick(); tick();
      rst = 1'b1;
   endtask

   task automatic test_reset;
      rst = 1'b0; req0 = 1'b1; req1 = 1'b1; addr0 = 32'h8; addr1 = 32'h10;
      tick();
      total++; if (gnt0 !== 1'b0)        begin bad++; $display("FAIL rst_gnt0 act=%0h exp=0", gnt0); end
      total++; if (gnt1 !== 1'b0)        begin bad++; $display("FAIL rst_gnt1 act=%0h exp=0", gnt1); end
      total++; if (rvalid0 !== 1'b0)     begin bad++; $display("FAIL rst_rvalid0 act=%0h exp=0", rvalid0); end
      total++; if (rvalid1 !== 1'b0)     begin bad++; $display("FAIL rst_rvalid1 act=%0h exp=0", rvalid1); end
      total++; if (rdata0 !== 32'h0)     begin bad++; $display("FAIL rst_rdata0 act=%0h exp=0", rdata0); end
      total++; if (rdata1 !== 32'h0)     begin bad++; $display("FAIL rst_rdata1 act=%0h exp=0", rdata1); end
      total++; if (err1 !== 1'b0)        begin bad++; $display("FAIL rst_err1 act=%0h exp=0", err1); end
      total++; if (mem_ce !== 1'b0)      begin bad++; $display("FAIL rst_mem_ce act=%0h exp=0", mem_ce); end
      total++; if (mem_idx !== 17'd0)    begin bad++; $display("FAIL rst_mem_idx act=%0h exp=0", mem_idx); end
      total++; if (stallreq_if !== 1'b0) begin bad++; $display("FAIL rst_stall act=%0h exp=0", stallreq_if); end
      req0 = 1'b0; req1 = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   task automatic test_single_fetch;
      req0 = 1'b1; addr0 = 32'h0000_0008;
      #1;
      total++; if (gnt0 !== 1'b1)        begin bad++; $display("FAIL t1_gnt0 act=%0h exp=1", gnt0); end
      total++; if (gnt1 !== 1'b0)        begin bad++; $display("FAIL t1_gnt1 act=%0h exp=0", gnt1); end
      total++; if (mem_ce !== 1'b1)      begin bad++; $display("FAIL t1_mem_ce act=%0h exp=1", mem_ce); end
      total++; if (mem_idx !== 17'd2)    begin bad++; $display("FAIL t1_mem_idx act=%0h exp=2", mem_idx); end
      total++; if (stallreq_if !== 1'b0) begin bad++; $display("FAIL t1_stall act=%0h exp=0", stallreq_if); end
      tick();
      req0 = 1'b0;
      #1;
      total++; if (rvalid0 !== 1'b1)          begin bad++; $display("FAIL t1_rvalid0 act=%0h exp=1", rvalid0); end
      total++; if (rdata0 !== 32'hA500_0002)  begin bad++; $display("FAIL t1_rdata0 act=%0h exp=a5000002", rdata0); end
      total++; if (rvalid1 !== 1'b0)          begin bad++; $display("FAIL t1_rvalid1 act=%0h exp=0", rvalid1); end
      tick();
      total++; if (rvalid0 !== 1'b0)          begin bad++; $display("FAIL t1_rvalid0_once act=%0h exp=0", rvalid0); end
   endtask

   task automatic test_contention;
      logic e0, e1, ev0, ev1;
      do_reset();
      req0 = 1'b1; addr0 = 32'h0; req1 = 1'b1; addr1 = 32'h10;
      for (int i = 0; i < 4; i++) begin
         e0  = (i % 2 == 0);
         e1  = (i % 2 == 1);
         ev0 = (i % 2 == 1);
         ev1 = (i > 0) && (i % 2 == 0);
         #1;
         total++; if (gnt0 !== e0)        begin bad++; $display("FAIL t2_gnt0[%0d] act=%0h exp=%0h", i, gnt0, e0); end
         total++; if (gnt1 !== e1)        begin bad++; $display("FAIL t2_gnt1[%0d] act=%0h exp=%0h", i, gnt1, e1); end
         total++; if (stallreq_if !== e1) begin bad++; $display("FAIL t2_stall[%0d] act=%0h exp=%0h", i, stallreq_if, e1); end
         total++; if (rvalid0 !== ev0)    begin bad++; $display("FAIL t2_rvalid0[%0d] act=%0h exp=%0h", i, rvalid0, ev0); end
         total++; if (rvalid1 !== ev1)    begin bad++; $display("FAIL t2_rvalid1[%0d] act=%0h exp=%0h", i, rvalid1, ev1); end
         if (ev0) begin
            total++; if (rdata0 !== 32'hA500_0000) begin bad++; $display("FAIL t2_rdata0[%0d] act=%0h exp=a5000000", i, rdata0); end
         end
         if (ev1) begin
            total++; if (rdata1 !== 32'hA500_0004) begin bad++; $display("FAIL t2_rdata1[%0d] act=%0h exp=a5000004", i, rdata1); end
         end
         tick();
      end
      req0 = 1'b0; req1 = 1'b0;
      #1;
      total++; if (rvalid1 !== 1'b1)         begin bad++; $display("FAIL t2_rvalid1_last act=%0h exp=1", rvalid1); end
      total++; if (rdata1 !== 32'hA500_0004) begin bad++; $display("FAIL t2_rdata1_last act=%0h exp=a5000004", rdata1); end
      total++; if (rdata0 !== 32'h0)         begin bad++; $display("FAIL t2_rdata0_idle act=%0h exp=0", rdata0); end
      tick();
   endtask

   task automatic test_misaligned;
      req1 = 1'b1; addr1 = 32'h0000_0006;
      #1;
      total++; if (gnt1 !== 1'b1)   begin bad++; $display("FAIL t3_gnt1 act=%0h exp=1", gnt1); end
      total++; if (gnt0 !== 1'b0)   begin bad++; $display("FAIL t3_gnt0 act=%0h exp=0", gnt0); end
      total++; if (mem_ce !== 1'b0) begin bad++; $display("FAIL t3_mem_ce act=%0h exp=0", mem_ce); end
      tick();
      req1 = 1'b0;
      #1;
      total++; if (rvalid1 !== 1'b1)  begin bad++; $display("FAIL t3_rvalid1 act=%0h exp=1", rvalid1); end
      total++; if (err1 !== 1'b1)     begin bad++; $display("FAIL t3_err1 act=%0h exp=1", err1); end
      total++; if (rdata1 !== 32'h0)  begin bad++; $display("FAIL t3_rdata1 act=%0h exp=0", rdata1); end
      total++; if (rvalid0 !== 1'b0)  begin bad++; $display("FAIL t3_rvalid0 act=%0h exp=0", rvalid0); end
      tick();
      total++; if (err1 !== 1'b0)     begin bad++; $display("FAIL t3_err1_clear act=%0h exp=0", err1); end
   endtask

   task automatic test_back_to_back;
      logic [31:0] exp_d;
      for (int i = 0; i < 3; i++) begin
         req0 = 1'b1; addr0 = 32'(i * 4);
         #1;
         total++; if (gnt0 !== 1'b1)         begin bad++; $display("FAIL t4_gnt0[%0d] act=%0h exp=1", i, gnt0); end
         total++; if (mem_idx !== 17'(i))    begin bad++; $display("FAIL t4_mem_idx[%0d] act=%0h exp=%0h", i, mem_idx, i); end
         if (i > 0) begin
            exp_d = 32'hA500_0000 + 32'(i - 1);
            total++; if (rvalid0 !== 1'b1)   begin bad++; $display("FAIL t4_rvalid0[%0d] act=%0h exp=1", i, rvalid0); end
            total++; if (rdata0 !== exp_d)   begin bad++; $display("FAIL t4_rdata0[%0d] act=%0h exp=%0h", i, rdata0, exp_d); end
         end
         tick();
      end
      req0 = 1'b0;
      #1;
      total++; if (rvalid0 !== 1'b1)         begin bad++; $display("FAIL t4_rvalid0_last act=%0h exp=1", rvalid0); end
      total++; if (rdata0 !== 32'hA500_0002) begin bad++; $display("FAIL t4_rdata0_last act=%0h exp=a5000002", rdata0); end
      tick();
   endtask

   task automatic test_reset_midread;
      req1 = 1'b1; addr1 = 32'h20;
      #1;
      total++; if (gnt1 !== 1'b1) begin bad++; $display("FAIL t5_gnt1 act=%0h exp=1", gnt1); end
      tick();
      req1 = 1'b0;
      rst  = 1'b0;
      #1;
      total++; if (rvalid1 !== 1'b0) begin bad++; $display("FAIL t5_rvalid1_rst act=%0h exp=0", rvalid1); end
      total++; if (rdata1 !== 32'h0) begin bad++; $display("FAIL t5_rdata1_rst act=%0h exp=0", rdata1); end
      total++; if (mem_ce !== 1'b0)  begin bad++; $display("FAIL t5_mem_ce_rst act=%0h exp=0", mem_ce); end
      tick();
      rst = 1'b1;
      #1;
      total++; if (rvalid1 !== 1'b0) begin bad++; $display("FAIL t5_rvalid1_rel act=%0h exp=0", rvalid1); end
      tick();
      total++; if (rvalid1 !== 1'b0) begin bad++; $display("FAIL t5_rvalid1_rel2 act=%0h exp=0", rvalid1); end
      req0 = 1'b1; addr0 = 32'h0; req1 = 1'b1; addr1 = 32'h10;
      #1;
      total++; if (gnt0 !== 1'b1)        begin bad++; $display("FAIL t5_first_gnt0 act=%0h exp=1", gnt0); end
      total++; if (gnt1 !== 1'b0)        begin bad++; $display("FAIL t5_first_gnt1 act=%0h exp=0", gnt1); end
      total++; if (stallreq_if !== 1'b0) begin bad++; $display("FAIL t5_stall act=%0h exp=0", stallreq_if); end
      tick();
      req0 = 1'b0; req1 = 1'b0;
      tick();
   endtask

   task automatic test_idle;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if (mem_ce !== 1'b0)  begin bad++; $display("FAIL t6_mem_ce[%0d] act=%0h exp=0", i, mem_ce); end
         total++; if (gnt0 !== 1'b0)    begin bad++; $display("FAIL t6_gnt0[%0d] act=%0h exp=0", i, gnt0); end
         total++; if (gnt1 !== 1'b0)    begin bad++; $display("FAIL t6_gnt1[%0d] act=%0h exp=0", i, gnt1); end
         total++; if (rvalid0 !== 1'b0) begin bad++; $display("FAIL t6_rvalid0[%0d] act=%0h exp=0", i, rvalid0); end
         total++; if (rvalid1 !== 1'b0) begin bad++; $display("FAIL t6_rvalid1[%0d] act=%0h exp=0", i, rvalid1); end
         tick();
      end
   endtask

   initial begin
      rst = 1'b0; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
      tick();
      test_reset();
      test_single_fetch();
      test_contention();
      test_misaligned();
      test_back_to_back();
      test_reset_midread();
      test_idle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
